// File: rtl/rv_fetch_unit_if.sv
// rv_fetch_unit_if: fetch-stage bus bundle toward instruction memory, redirect source and decode.
interface rv_fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-3:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;
  logic            redir_valid;
  logic [XLEN-1:0] redir_pc;
  logic            if_valid;
  logic            if_ready;
  logic [XLEN-1:0] if_pc;
  logic [XLEN-1:0] if_instr;
  modport master (
    output imem_req, imem_addr, if_valid, if_pc, if_instr,
    input  imem_rvalid, imem_rdata, redir_valid, redir_pc, if_ready
  );
  modport slave (
    input  imem_req, imem_addr, if_valid, if_pc, if_instr,
    output imem_rvalid, imem_rdata, redir_valid, redir_pc, if_ready
  );
endinterface

// File: rtl/rv_fetch_unit.sv
// rv_fetch_unit: RV32 fetch stage with reset vector, redirect, decode handshake and a slot buffer for variable imem latency.
module rv_fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input logic             clk,
  input logic             rst,
  rv_fetch_unit_if.master bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int DW = $clog2(2 * DEPTH) + 1;

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  spc_q [DEPTH];
  logic [XLEN-1:0]  spc_d [DEPTH];
  logic [XLEN-1:0]  sins_q [DEPTH];
  logic [XLEN-1:0]  sins_d [DEPTH];
  logic [DEPTH-1:0] sful_q, sful_d;
  logic [PW-1:0]    head_q, head_d, tail_q, tail_d, fill_q, fill_d;
  logic [CW-1:0]    used_q, used_d, pend_q, pend_d;
  logic [DW-1:0]    drop_q, drop_d;
  logic             if_valid_q, if_valid_d;
  logic [XLEN-1:0]  if_pc_q, if_pc_d, if_instr_q, if_instr_d;
  logic             issue, pop, stale, fill;

  always_comb begin
    issue = !rst && used_q < CW'(DEPTH) && !bus.redir_valid;
    pop = if_valid_q && bus.if_ready;
    stale = bus.imem_rvalid && drop_q != '0;
    fill = bus.imem_rvalid && !stale && pend_q != '0;
    pc_d = pc_q;
    spc_d = spc_q;
    sins_d = sins_q;
    sful_d = sful_q;
    head_d = head_q;
    tail_d = tail_q;
    fill_d = fill_q;
    used_d = used_q;
    pend_d = pend_q;
    drop_d = drop_q;
    if (bus.redir_valid) begin
      // every unfilled slot still has a response coming back; a same-cycle response is one of them
      pc_d = bus.redir_pc & ~XLEN'(3);
      sful_d = '0;
      head_d = '0;
      tail_d = '0;
      fill_d = '0;
      used_d = '0;
      pend_d = '0;
      drop_d = drop_q + DW'(pend_q) - DW'(bus.imem_rvalid && (drop_q != '0 || pend_q != '0));
    end else begin
      if (pop) begin
        sful_d[head_q] = 1'b0;
        head_d = head_q + PW'(1);
      end
      if (issue) begin
        spc_d[tail_q] = pc_q;
        sful_d[tail_q] = 1'b0;
        tail_d = tail_q + PW'(1);
        pc_d = pc_q + XLEN'(4);
      end
      if (fill) begin
        sins_d[fill_q] = bus.imem_rdata;
        sful_d[fill_q] = 1'b1;
        fill_d = fill_q + PW'(1);
      end
      drop_d = stale ? drop_q - DW'(1) : drop_q;
      used_d = used_q + CW'(issue) - CW'(pop);
      pend_d = pend_q + CW'(issue) - CW'(fill);
    end
    if_valid_d = sful_d[head_d];
    if_pc_d = spc_d[head_d];
    if_instr_d = sins_d[head_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
      spc_q <= '{default: '0};
      sins_q <= '{default: '0};
      sful_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
      used_q <= '0;
      pend_q <= '0;
      drop_q <= '0;
      if_valid_q <= 1'b0;
      if_pc_q <= '0;
      if_instr_q <= '0;
    end else begin
      pc_q <= pc_d;
      spc_q <= spc_d;
      sins_q <= sins_d;
      sful_q <= sful_d;
      head_q <= head_d;
      tail_q <= tail_d;
      fill_q <= fill_d;
      used_q <= used_d;
      pend_q <= pend_d;
      drop_q <= drop_d;
      if_valid_q <= if_valid_d;
      if_pc_q <= if_pc_d;
      if_instr_q <= if_instr_d;
    end
  end

  assign bus.imem_req = issue;
  assign bus.imem_addr = pc_q[XLEN-1:2];
  assign bus.if_valid = if_valid_q;
  assign bus.if_pc = if_pc_q;
  assign bus.if_instr = if_instr_q;
endmodule

// File: doc/rv_fetch_unit.md
Name: rv_fetch_unit

Overview:
Parametrised instruction-fetch stage for the RV32 pipeline. It replaces the free-running PC+4 counter with four additions: a configurable reset vector, a branch/jump redirect port, a valid/ready handshake toward decode, and a slot buffer that covers variable instruction-memory latency. The block sits between the instruction memory and the decode stage.

Parameters:
XLEN, 32, PC and instruction width in bits.
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
DEPTH, 4, number of fetch slots (in-flight plus buffered); power of two, 2..16.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
imem_req  out  1  fetch request strobe, one word per cycle
imem_addr  out  XLEN-2  word address (PC[XLEN-1:2])
imem_rvalid  in  1  response strobe; responses return in request order, latency >= 1 cycle
imem_rdata  in  XLEN  instruction word for the oldest outstanding request
redir_valid  in  1  redirect strobe from branch/jump resolution
redir_pc  in  XLEN  redirect target; bits [1:0] ignored (forced to 0)
if_valid  out  1  head slot holds an instruction
if_ready  in  1  decode accepts the head this cycle
if_pc  out  XLEN  PC of the head instruction
if_instr  out  XLEN  head instruction

Behaviour:
- Reset (async, active-high) clears all state:
  - pc = RESET_PC.
  - All slots free; head = tail = 0; drop_cnt = 0.
  - imem_req = 0, if_valid = 0, if_pc = 0, if_instr = 0.
- Slot buffer: circular array of DEPTH entries {pc, instr, filled}, plus a count of used slots.
  - A slot is allocated at request time and filled when its response returns.
- Issue rule: imem_req = 1 when used < DEPTH and redir_valid = 0.
  - On issue: slot[tail].pc = pc, filled = 0; tail++ (wraps mod DEPTH); pc += 4, wrapping at 2^XLEN.
- Response: on imem_rvalid with drop_cnt = 0:
  - Write instr into the oldest unfilled slot and set filled = 1.
  - Fill pointer advances in order, wraps mod DEPTH.
- Output: if_valid = slot[head].filled; if_pc and if_instr driven from slot[head], registered.
  - Pop on if_valid & if_ready: head++, used--.
- Same-cycle issue + response + pop all update consistently; used changes by (+issue - pop).
- Full: used = DEPTH blocks issue. Filled slots remain stable while if_ready = 0.
- Redirect (redir_valid = 1), highest priority:
  - pc = {redir_pc[XLEN-1:2], 2'b00}; all slots freed; head = tail = fill = 0.
  - drop_cnt += number of issued-but-unfilled slots.
  - No request issued that cycle; the first request to the target goes out the next cycle.
  - A pop in the same cycle still counts as consumed by decode. A response in the same cycle is treated as stale and decrements the drop count.
  - if_valid = 0 in the cycle after a redirect.
- Stale responses: while drop_cnt > 0, each imem_rvalid decrements drop_cnt and its data is discarded.
  - Requests to the new target may issue while drops are pending. drop_cnt width is log2(2*DEPTH)+1.
- An imem_rvalid with no outstanding request and drop_cnt = 0 is a protocol error; it is ignored (assertion in bench).
- Latency: decode sees the first instruction after reset at the earliest 2 cycles after rst deasserts (request, 1-cycle memory, registered output).

Test Plan:
1. Reset with RESET_PC=0x100, 1-cycle memory, if_ready=1 -> imem_addr 0x40, 0x41, 0x42…; if_pc 0x100, 0x104, 0x108 on consecutive cycles; first if_valid 2 cycles after reset release.
2. if_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests issued then imem_req=0. On release, instructions arrive in order with no loss or duplication.
3. Memory latency 3 cycles, redirect to 0x2002 with 3 requests in flight -> the 3 stale responses are dropped; next if_pc = 0x2000; no pre-redirect PC appears after the redirect.
4. Redirect in the same cycle as a pop and a stale response -> the popped instruction counts once, the response is discarded, the next imem_addr is the target word.
5. PC at 0xFFFF_FFFC -> next fetch PC wraps to 0x0000_0000.
6. Assert rst mid-stream with slots full and drops pending -> outputs clear immediately; after release, fetch restarts at RESET_PC and drop_cnt = 0.
